// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with speculative allocation,
// commit tracking, flush rollback and compacted multi-port release.
module phys_reg_free_list #(
  parameter int unsigned PREG_W      = 6,
  parameter int unsigned FL_DEPTH    = 32,
  parameter int unsigned INIT_BASE   = 32,
  parameter int unsigned ALLOC_PORTS = 2,
  parameter int unsigned REL_PORTS   = 2
) (
  input  logic                            Clk,
  input  logic                            Rest,
  input  logic [ALLOC_PORTS-1:0]          AllocReq,
  output logic [ALLOC_PORTS*PREG_W-1:0]   AllocPreg,
  output logic                            AllocReady,
  input  logic [REL_PORTS-1:0]            RelValid,
  input  logic [REL_PORTS*PREG_W-1:0]     RelPreg,
  input  logic [$clog2(ALLOC_PORTS):0]    CommitAllocNum,
  input  logic                            FlClean,
  output logic [$clog2(FL_DEPTH):0]       FreeCount,
  output logic                            FlEmpty,
  output logic                            FlFull,
  output logic                            FlOverflow
);

  localparam int unsigned IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = PTR_W;

  logic [PREG_W-1:0] mem [FL_DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] chead_q;

  logic [CNT_W-1:0] alloc_n;
  logic             alloc_fire;
  logic [PTR_W-1:0] chead_nxt;
  logic [PTR_W-1:0] head_nxt;
  logic [CNT_W-1:0] rel_n;
  logic [CNT_W-1:0] rel_rank [REL_PORTS];
  logic [CNT_W-1:0] room;
  logic [CNT_W-1:0] rel_acc;
  logic [REL_PORTS-1:0] rel_we;
  logic             rel_ovf;
  logic [PTR_W-1:0] tail_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Look-ahead tags at head, head+1, ...
  always_comb begin
    AllocPreg = '0;
    for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
      AllocPreg[k*PREG_W +: PREG_W] = mem[IDX_W'(head_q + PTR_W'(k))];
    end
  end

  // Allocation grant and head / committed-head update
  always_comb begin
    alloc_n = '0;
    for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
      alloc_n = alloc_n + CNT_W'(AllocReq[k]);
    end
    AllocReady = (FreeCount >= alloc_n);
    alloc_fire = (|AllocReq) && AllocReady && !FlClean;
    chead_nxt  = chead_q + PTR_W'(CommitAllocNum);
    head_nxt   = FlClean ? chead_nxt : head_q + (alloc_fire ? alloc_n : '0);
  end

  // Compact valid releases and clip them to the space left after head moves
  always_comb begin
    rel_n = '0;
    for (int k = 0; k < int'(REL_PORTS); k++) begin
      rel_rank[k] = rel_n;
      rel_n       = rel_n + CNT_W'(RelValid[k]);
    end
    room     = CNT_W'(FL_DEPTH) - (tail_q - head_nxt);
    rel_ovf  = (rel_n > room);
    rel_acc  = rel_ovf ? room : rel_n;
    rel_we   = '0;
    for (int k = 0; k < int'(REL_PORTS); k++) begin
      rel_we[k] = RelValid[k] && (rel_rank[k] < rel_acc);
    end
    tail_nxt = tail_q + rel_acc;
    cnt_nxt  = tail_nxt - head_nxt;
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        mem[IDX_W'(i)] <= PREG_W'(INIT_BASE + i);
      end
    end else begin
      for (int k = 0; k < int'(REL_PORTS); k++) begin
        if (rel_we[k]) begin
          mem[IDX_W'(tail_q + rel_rank[k])] <= RelPreg[k*PREG_W +: PREG_W];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      head_q     <= '0;
      chead_q    <= '0;
      tail_q     <= PTR_W'(FL_DEPTH);
      FreeCount  <= CNT_W'(FL_DEPTH);
      FlEmpty    <= 1'b0;
      FlFull     <= 1'b1;
      FlOverflow <= 1'b0;
    end else begin
      head_q     <= head_nxt;
      chead_q    <= chead_nxt;
      tail_q     <= tail_nxt;
      FreeCount  <= cnt_nxt;
      FlEmpty    <= (cnt_nxt == '0);
      FlFull     <= (cnt_nxt == CNT_W'(FL_DEPTH));
      FlOverflow <= FlOverflow | rel_ovf;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: queue-based free-list model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_phys_reg_free_list;

  logic        Clk = 1'b0;
  logic        Rest;
  logic [1:0]  AllocReq;
  logic [11:0] AllocPreg;
  logic        AllocReady;
  logic [1:0]  RelValid;
  logic [11:0] RelPreg;
  logic [1:0]  CommitAllocNum;
  logic        FlClean;
  logic [5:0]  FreeCount;
  logic        FlEmpty;
  logic        FlFull;
  logic        FlOverflow;

  int total  = 0;
  int passed = 0;

  phys_reg_free_list dut (
    .Clk            (Clk),
    .Rest           (Rest),
    .AllocReq       (AllocReq),
    .AllocPreg      (AllocPreg),
    .AllocReady     (AllocReady),
    .RelValid       (RelValid),
    .RelPreg        (RelPreg),
    .CommitAllocNum (CommitAllocNum),
    .FlClean        (FlClean),
    .FreeCount      (FreeCount),
    .FlEmpty        (FlEmpty),
    .FlFull         (FlFull),
    .FlOverflow     (FlOverflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int slot(input int k);
    return int'(AllocPreg[k*6 +: 6]);
  endfunction

  // Model: ordered free tags, in-flight speculative tags, sticky overflow
  int free_q[$];
  int spec_q[$];
  bit m_ovf;

  always @(posedge Clk or posedge Rest) begin
    int n;
    int room;
    if (Rest) begin
      free_q.delete();
      spec_q.delete();
      for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
      m_ovf = 1'b0;
    end else begin
      n = $countones(AllocReq);
      if (FlClean) begin
        repeat (CommitAllocNum) void'(spec_q.pop_front());
        for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
        spec_q.delete();
      end else begin
        if (n != 0 && free_q.size() >= n)
          repeat (n) spec_q.push_back(free_q.pop_front());
        repeat (CommitAllocNum) void'(spec_q.pop_front());
      end
      room = 32 - free_q.size();
      for (int k = 0; k < 2; k++) begin
        if (RelValid[k]) begin
          if (room > 0) begin
            free_q.push_back(int'(RelPreg[k*6 +: 6]));
            room--;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    if (!Rest) begin
      chk("m_count", int'(FreeCount), free_q.size());
      chk("m_empty", int'(FlEmpty), int'(free_q.size() == 0));
      chk("m_full", int'(FlFull), int'(free_q.size() == 32));
      chk("m_ovf", int'(FlOverflow), int'(m_ovf));
      chk("m_ready", int'(AllocReady), int'(free_q.size() >= $countones(AllocReq)));
      for (int k = 0; k < 2; k++)
        if (k < free_q.size()) chk($sformatf("m_slot%0d", k), slot(k), free_q[k]);
    end
  end

  task automatic idle_inputs();
    AllocReq = '0; RelValid = '0; RelPreg = '0; CommitAllocNum = '0; FlClean = 1'b0;
  endtask

  task automatic cyc(input logic [1:0] a, input logic [1:0] rv, input int p0,
                     input int p1, input int cn, input logic fl);
    AllocReq = a; RelValid = rv; RelPreg = {6'(p1), 6'(p0)};
    CommitAllocNum = 2'(cn); FlClean = fl;
    @(posedge Clk); #2;
    idle_inputs();
  endtask

  task automatic do_reset();
    Rest = 1'b1;
    @(posedge Clk); #2;
    Rest = 1'b0;
  endtask

  initial begin
    int prev;
    int exp_tag;
    Rest = 1'b1;
    idle_inputs();
    @(posedge Clk); #2;
    Rest = 1'b0;

    // Reset state
    chk("rst_count", int'(FreeCount), 32);
    chk("rst_full", int'(FlFull), 1);
    chk("rst_empty", int'(FlEmpty), 0);
    chk("rst_ovf", int'(FlOverflow), 0);
    chk("rst_ready", int'(AllocReady), 1);
    chk("rst_slot0", slot(0), 32);
    chk("rst_slot1", slot(1), 33);

    // Double allocation after reset
    cyc(2'b11, 2'b00, 0, 0, 0, 1'b0);
    chk("dual_count", int'(FreeCount), 30);
    chk("dual_slot0", slot(0), 34);
    chk("dual_slot1", slot(1), 35);

    // Reset mid-operation overrides pending request
    AllocReq = 2'b11;
    Rest = 1'b1;
    #1;
    chk("async_rst_count", int'(FreeCount), 32);
    chk("async_rst_slot0", slot(0), 32);
    @(posedge Clk); #2;
    Rest = 1'b0;
    AllocReq = 2'b00;
    chk("rst_hold_count", int'(FreeCount), 32);
    cyc(2'b01, 2'b00, 0, 0, 0, 1'b0);
    chk("first_op_count", int'(FreeCount), 31);
    chk("first_op_slot0", slot(0), 33);

    // Drain to empty, then alloc blocked while a release lands
    do_reset();
    repeat (16) cyc(2'b11, 2'b00, 0, 0, 0, 1'b0);
    chk("drain_count", int'(FreeCount), 0);
    chk("drain_empty", int'(FlEmpty), 1);
    AllocReq = 2'b01;
    #1;
    chk("drain_ready", int'(AllocReady), 0);
    cyc(2'b01, 2'b10, 0, 5, 0, 1'b0);
    chk("rel_empty_count", int'(FreeCount), 1);
    chk("rel_empty_slot0", slot(0), 5);
    chk("rel_empty_flag", int'(FlEmpty), 0);

    // Flush restores uncommitted allocations
    do_reset();
    cyc(2'b11, 2'b00, 0, 0, 0, 1'b0);
    cyc(2'b11, 2'b00, 0, 0, 2, 1'b0);
    cyc(2'b11, 2'b00, 0, 0, 0, 1'b0);
    chk("pre_flush_count", int'(FreeCount), 26);
    cyc(2'b00, 2'b00, 0, 0, 0, 1'b1);
    chk("flush_count", int'(FreeCount), 30);
    chk("flush_slot0", slot(0), 34);
    chk("flush_slot1", slot(1), 35);

    // Flush with releases and an ignored allocation request
    do_reset();
    cyc(2'b11, 2'b00, 0, 0, 0, 1'b0);
    cyc(2'b11, 2'b00, 0, 0, 2, 1'b0);
    chk("pre_fr_count", int'(FreeCount), 28);
    cyc(2'b11, 2'b11, 40, 41, 0, 1'b1);
    chk("fr_count", int'(FreeCount), 32);
    chk("fr_full", int'(FlFull), 1);
    chk("fr_ovf", int'(FlOverflow), 0);
    chk("fr_slot0", slot(0), 34);
    repeat (15) cyc(2'b11, 2'b00, 0, 0, 0, 1'b0);
    chk("fr_tail_slot0", slot(0), 40);
    chk("fr_tail_slot1", slot(1), 41);
    chk("fr_tail_count", int'(FreeCount), 2);

    // Release into a full list overflows and is dropped
    do_reset();
    cyc(2'b00, 2'b01, 7, 0, 0, 1'b0);
    chk("ovf_flag", int'(FlOverflow), 1);
    chk("ovf_count", int'(FreeCount), 32);
    chk("ovf_slot0", slot(0), 32);
    cyc(2'b00, 2'b00, 0, 0, 0, 1'b0);
    chk("ovf_sticky", int'(FlOverflow), 1);
    do_reset();
    chk("ovf_cleared", int'(FlOverflow), 0);

    // Partial overflow: first compacted release kept, second dropped
    cyc(2'b01, 2'b00, 0, 0, 0, 1'b0);
    cyc(2'b00, 2'b11, 9, 10, 0, 1'b0);
    chk("povf_flag", int'(FlOverflow), 1);
    chk("povf_count", int'(FreeCount), 32);
    repeat (15) cyc(2'b11, 2'b00, 0, 0, 0, 1'b0);
    chk("povf_slot0", slot(0), 63);
    chk("povf_slot1", slot(1), 9);

    // Round trips across pointer wrap
    do_reset();
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      exp_tag = 32 + (i % 32);
      chk($sformatf("rt_tag%0d", i), slot(0), exp_tag);
      cyc(2'b01, (i > 0) ? 2'b01 : 2'b00, prev, 0, 1, 1'b0);
      chk($sformatf("rt_count%0d", i), int'(FreeCount), 31);
      prev = exp_tag;
    end

    @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
